ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit: owns the PC, issues one word fetch at a time to instruction
//  memory, and presents the returned word to control_unit with a valid/ready handshake.
//  Takes jump targets (is_jal/is_jalr, computed downstream) back as a redirect.
//  Discards any fetch that is still in flight when a redirect arrives.
// PARAMETERS
//  RESET_PC  32'h8000_0000  first fetch address after reset
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous reset, active-high
//  imem_req         out  1   fetch request, valid in S_REQ only
//  imem_addr        out  32  fetch address (= pc_q), word aligned
//  imem_gnt         in   1   memory accepts request this cycle (imem_req & imem_gnt)
//  imem_rvalid      in   1   read data valid; never in the cycle of its own grant
//  imem_rdata       in   32  fetched instruction word
//  inst_valid       out  1   instruction/pc hold a fetched word (S_HOLD)
//  instruction      out  32  fetched word, stable while inst_valid
//  pc               out  32  address of instruction
//  inst_ready       in   1   consumer takes instruction (inst_valid & inst_ready)
//  redirect_valid   in   1   jump taken (JAL/JALR); overrides all else
//  redirect_target  in   32  new PC; bits[1:0] forced to 0
// BEHAVIOUR
//  State: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP. Outputs decoded from registered state.
//  Reset (async): state=S_IDLE, pc_q=RESET_PC, instruction=0, imem_req=0, inst_valid=0.
//  S_IDLE: -> S_REQ on the first clock after rst deasserts. Entered only from reset.
//  S_REQ:  imem_req=1. On gnt: -> S_WAIT. No gnt: stay in S_REQ, address held.
//  S_WAIT: on rvalid: capture rdata into instruction, -> S_HOLD.
//  S_HOLD: inst_valid=1. On inst_ready: pc_q<=pc_q+4 (mod 2^32 wrap), -> S_REQ.
//  S_DROP: fetch outstanding but stale. On rvalid: discard data, -> S_REQ.
//  Redirect (highest priority, any state except S_IDLE): pc_q<={target[31:2],2'b00}.
//   S_REQ & gnt same cycle -> S_DROP. S_REQ without gnt -> stay S_REQ, new address.
//   S_WAIT & rvalid same cycle -> S_REQ, data dropped. S_WAIT, no rvalid -> S_DROP.
//   S_HOLD -> S_REQ: inst_valid drops next cycle. inst_ready ignored, no +4.
//   S_DROP: stay S_DROP (or -> S_REQ if rvalid same cycle). Latest target wins.
//  Redirect in S_IDLE is ignored.
//  Latency: gnt in S_REQ at cycle N, rvalid at N+1 -> inst_valid at N+2.
//   Best throughput is 1 instruction per 3 cycles.
//  At most one outstanding memory transaction. Data returned in S_DROP is never shown.
//  instruction/pc change only on entry to S_HOLD. They are stable while inst_valid=1.
//  Reset mid-operation: immediate return to reset values; outstanding rvalid ignored.
// TESTING
//  1 Release reset, gnt=1, rvalid 1 cycle later -> imem_addr=0x80000000;
//    inst_valid at 3rd clk; pc=0x80000000.
//  2 Hold inst_ready=0 for 5 cycles -> instruction/pc stable, imem_req=0.
//    Then ready=1 -> next imem_addr=0x80000004.
//  3 Redirect to 0x80000103 in S_WAIT, no rvalid -> S_DROP.
//    Stale rdata is not shown; next imem_addr=0x80000100.
//  4 Redirect in S_HOLD with inst_ready=1 same cycle -> no +4.
//    inst_valid=0 next cycle; imem_addr=target.
//  5 pc_q=0xFFFFFFFC accepted -> next imem_addr=0x00000000 (wrap).
//  6 Assert rst during S_WAIT, then rvalid after release -> ignored.
//    Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single outstanding word fetches and
// hands fetched words to the consumer over a valid/ready handshake, honouring redirects.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q;
    logic [31:0] inst_pc_q;
    logic        capture;
    logic [31:0] target_aligned;

    assign target_aligned = {redirect_target[31:2], 2'b00};

    // Redirect takes priority everywhere but S_IDLE; a fetch already granted becomes stale.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = target_aligned;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                instr_q   <= imem_rdata;
                inst_pc_q <= pc_q;
            end
        end
    end

    // pc is a separate copy so it only moves when a new word enters S_HOLD.
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == S_HOLD);
    assign instruction = instr_q;
    assign pc          = inst_pc_q;

endmodule
